mul_issue_ctrl: RTL and testbench
=================================

// Module: mul_issue_ctrl
// PURPOSE
//  Front/back-end controller for the unsigned iterative multiplier. Sits between the CPU
//  EX stage and the multiplier.
//  Decodes RV32M MUL/MULH/MULHSU/MULHU and drives magnitudes plus a start pulse into the
//  multiplier. Captures its 64-bit unsigned product, restores the sign and returns the
//  selected 32-bit half.
//  Keeps a one-entry result cache, so that MULH followed by MUL on the same operands
//  completes without re-running the multiplier.
// PARAMETERS
//  XLEN      32   operand width; product is 2*XLEN
//  TIMEOUT   64   max cycles in WAIT before abort
//  REUSE_EN  1    1 = one-entry result cache enabled; 0 = every request misses
// PORTS
//  clk            in   1     single clock, rising edge
//  rst            in   1     synchronous, active-high reset
//  req_valid      in   1     request strobe from EX, sampled only in IDLE
//  req_op         in   2     00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//  req_rs1        in   XLEN  operand a (signed for MUL/MULH/MULHSU)
//  req_rs2        in   XLEN  operand b (signed for MUL/MULH)
//  result         out  XLEN  selected half, valid only with result_valid
//  result_valid   out  1     one-cycle pulse in DONE
//  err            out  1     one-cycle pulse in DONE when the request timed out
//  stall          out  1     hold the pipeline
//  mul_in_valid   out  1     one-cycle start pulse to the multiplier
//  mul_mplier     out  XLEN  |a| to the multiplier
//  mul_mcand      out  XLEN  |b| to the multiplier
//  mul_product    in   2*XLEN unsigned product
//  mul_out_valid  in   1     product valid, one-cycle pulse
// BEHAVIOUR
//  Reset: state=IDLE, TO counter 0, cache invalid.
//    All outputs are 0: result, result_valid, err, stall, mul_in_valid, mul_mplier, mul_mcand.
//  Sign flags: sa = (op!=MULHU); sb = (op==MUL||op==MULH); neg_a = sa&rs1[XLEN-1];
//    neg_b = sb&rs2[XLEN-1]; neg = neg_a^neg_b.
//  Magnitudes: |a| = neg_a ? (~rs1+1) : rs1, as XLEN-bit unsigned. 0x80000000 maps to
//    2^31, which is correct. Same rule for |b|.
//  Result: P = neg ? (~product+1) : product, 64-bit wrap.
//    result = P[XLEN-1:0] for MUL, P[2XLEN-1:XLEN] otherwise.
//  MUL low half is sign-independent, so MUL is treated as sa=sb=1.
//  FSM:
//   IDLE   On req_valid: latch op/rs1/rs2/neg. Cache hit -> DONE; else -> ISSUE.
//          Hit = REUSE_EN & valid & rs1==key_a & rs2==key_b & (op==MUL | {sa,sb}==key_s).
//   ISSUE  mul_in_valid=1 for exactly 1 cycle; mul_mplier/mul_mcand driven with the
//          magnitudes, held stable ISSUE..WAIT. -> WAIT.
//   WAIT   TO counter increments each cycle.
//          mul_out_valid -> capture product, -> FIX.
//          TO==TIMEOUT-1 without it -> DONE with err=1, result=0, cache invalidated.
//          If mul_out_valid arrives on that same cycle, the product wins.
//   FIX    Compute P and latch it into the cache: key={rs1,rs2,{sa,sb}}, valid=1. -> DONE.
//   DONE   result_valid=1 (err as set), stall=0. -> IDLE.
//  stall = (IDLE&req_valid) | ISSUE | WAIT | FIX. Deasserted in DONE, which mirrors the
//    multiplier's own stall.
//  Latency, request-to-result_valid: hit = 1 cycle; miss = Lmul+3, where Lmul = cycles
//    from mul_in_valid to mul_out_valid.
//  Ignored inputs:
//    req_valid outside IDLE (EX is stalled by contract).
//    mul_out_valid outside WAIT.
//    req_valid in DONE; it is taken on the next IDLE cycle.
//  result is held after DONE until the next DONE; it is 0 until the first DONE.
//  rst at any state (including WAIT with the multiplier busy) -> IDLE next cycle, cache
//    invalid. A late mul_out_valid is discarded because the FSM is not in WAIT.
// STRUCTURE
//  mul_pkg: MUL_OP_* encodings (2'b00..2'b11), state encoding (IDLE, ISSUE, WAIT, FIX,
//    DONE as 3-bit localparams), XLEN default.
//  Sub-module mul_sign_fix: combinational abs for both operands, and negate plus half-select
//    on the 64-bit product. Instantiated once; the FSM, TO counter and cache live in top.
// TESTING  (bench uses the real multiplier; Lmul measured, not hard-coded)
//  1. MULHU a=0xFFFFFFFF b=0xFFFFFFFF -> mplier=mcand=0xFFFFFFFF;
//     product 0xFFFFFFFE_00000001; result=0xFFFFFFFE, err=0.
//  2. MULH a=0xFFFFFFFF b=2 -> mcand=2, mplier=1; P=0xFFFFFFFF_FFFFFFFE, result=0xFFFFFFFF.
//     Then MUL with the same operands -> no mul_in_valid, result_valid 1 cycle after
//     req_valid, result=0xFFFFFFFE.
//  3. MULH a=b=0x80000000 -> magnitudes 0x80000000; result=0x40000000.
//     Then MULHU with the same operands -> miss (key_s differs), result=0x40000000
//     via a fresh multiplier run.
//  4. MULHSU a=0xFFFFFFFF b=0xFFFFFFFF -> P=0xFFFFFFFF_00000001, result=0xFFFFFFFF.
//     MULHSU a=5 b=0x80000000 -> result=0x00000002.
//  5. Stubbed multiplier never raises mul_out_valid -> DONE exactly TIMEOUT cycles after
//     entering WAIT; err=1, result=0. An immediate identical request misses.
//  6. rst pulse while in WAIT -> all outputs 0 next cycle; a late mul_out_valid is ignored;
//     repeating the prior request issues mul_in_valid (cache cleared).

Source files
------------

// File: rtl/mul_pkg.sv
// Purpose : shared encodings for the RV32M multiply issue controller.
// Contents: operand-width default, RV32M multiply opcode encodings,
//           3-bit FSM state encodings and the operand signedness decode.
package mul_pkg;

  localparam int XLEN_DEF = 32;

  // RV32M multiply variants as presented on req_op.
  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  // Controller FSM states.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_FIX   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Returns {sa, sb}: whether operand a / operand b is treated as signed.
  // MUL only keeps the low half, which is sign-independent, so it is
  // decoded as fully signed and shares a cache key with MULH.
  function automatic logic [1:0] sign_flags(input logic [1:0] op);
    logic [1:0] f;
    case (op)
      MUL_OP_MUL:    f = 2'b11;
      MUL_OP_MULH:   f = 2'b11;
      MUL_OP_MULHSU: f = 2'b10;
      MUL_OP_MULHU:  f = 2'b00;
      default:       f = 2'b00;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/mul_sign_fix.sv
// Purpose : combinational sign handling around the unsigned multiplier.
// Ports   : op/rs1/rs2       -> abs_a, abs_b (magnitudes), neg (result sign)
//           prod/prod_neg    -> p_fixed (two's-complement restored product)
//           sel_hi           -> half (upper or lower XLEN bits of p_fixed)
module mul_sign_fix
  import mul_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [1:0]        op,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   rs2,
  output logic [XLEN-1:0]   abs_a,
  output logic [XLEN-1:0]   abs_b,
  output logic              neg,
  input  logic [2*XLEN-1:0] prod,
  input  logic              prod_neg,
  input  logic              sel_hi,
  output logic [2*XLEN-1:0] p_fixed,
  output logic [XLEN-1:0]   half
);

  localparam logic [XLEN-1:0]   ONE_X = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] ONE_P = {{(2*XLEN-1){1'b0}}, 1'b1};

  logic [1:0] flags_s;
  logic       neg_a_s;
  logic       neg_b_s;

  // Operand magnitudes; the most negative value maps onto 2^(XLEN-1) unsigned.
  always_comb begin
    flags_s = sign_flags(op);
    neg_a_s = flags_s[1] & rs1[XLEN-1];
    neg_b_s = flags_s[0] & rs2[XLEN-1];
    neg     = neg_a_s ^ neg_b_s;
    abs_a   = neg_a_s ? (~rs1 + ONE_X) : rs1;
    abs_b   = neg_b_s ? (~rs2 + ONE_X) : rs2;
  end

  // Sign restore on the full product (2*XLEN wrap) and half select.
  always_comb begin
    p_fixed = prod_neg ? (~prod + ONE_P) : prod;
    half    = sel_hi ? p_fixed[2*XLEN-1:XLEN] : p_fixed[XLEN-1:0];
  end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Purpose : issue/return controller between the EX stage and an unsigned
//           iterative multiplier, with a one-entry result cache.
// Ports   : clk, rst (sync, active-high)
//           req_valid/req_op/req_rs1/req_rs2 : request from EX (taken in IDLE)
//           result/result_valid/err          : one-cycle completion in DONE
//           stall                            : holds the pipeline while busy
//           mul_in_valid/mul_mplier/mul_mcand: start pulse + magnitudes out
//           mul_product/mul_out_valid        : unsigned product back
module mul_issue_ctrl
  import mul_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int TIMEOUT  = 64,
  parameter int REUSE_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [1:0]        req_op,
  input  logic [XLEN-1:0]   req_rs1,
  input  logic [XLEN-1:0]   req_rs2,
  output logic [XLEN-1:0]   result,
  output logic              result_valid,
  output logic              err,
  output logic              stall,
  output logic              mul_in_valid,
  output logic [XLEN-1:0]   mul_mplier,
  output logic [XLEN-1:0]   mul_mcand,
  input  logic [2*XLEN-1:0] mul_product,
  input  logic              mul_out_valid
);

  localparam int              TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

  logic [2:0]        state_q, state_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   rs1_q, rs1_d, rs2_q, rs2_d;
  logic              neg_q, neg_d;
  logic [2*XLEN-1:0] product_q, product_d;
  logic              cache_valid_q, cache_valid_d;
  logic [XLEN-1:0]   key_a_q, key_a_d, key_b_q, key_b_d;
  logic [1:0]        key_s_q, key_s_d;
  logic [2*XLEN-1:0] cache_p_q, cache_p_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              result_valid_q, result_valid_d;
  logic              err_q, err_d;
  logic              mul_in_valid_q, mul_in_valid_d;
  logic [XLEN-1:0]   mplier_q, mplier_d, mcand_q, mcand_d;

  logic [XLEN-1:0]   abs_a_s, abs_b_s;
  logic              neg_s;
  logic [2*XLEN-1:0] fix_prod_s, fix_p_s;
  logic              fix_neg_s, fix_hi_s;
  logic [XLEN-1:0]   fix_half_s;
  logic              hit_s;

  mul_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .op      (req_op),
    .rs1     (req_rs1),
    .rs2     (req_rs2),
    .abs_a   (abs_a_s),
    .abs_b   (abs_b_s),
    .neg     (neg_s),
    .prod    (fix_prod_s),
    .prod_neg(fix_neg_s),
    .sel_hi  (fix_hi_s),
    .p_fixed (fix_p_s),
    .half    (fix_half_s)
  );

  // Product-side mux: FIX fixes the fresh product; otherwise the cached,
  // already sign-restored product is half-selected for a hit in IDLE.
  always_comb begin
    if (state_q == ST_FIX) begin
      fix_prod_s = product_q;
      fix_neg_s  = neg_q;
      fix_hi_s   = (op_q != MUL_OP_MUL);
    end else begin
      fix_prod_s = cache_p_q;
      fix_neg_s  = 1'b0;
      fix_hi_s   = (req_op != MUL_OP_MUL);
    end
  end

  // Cache lookup; MUL hits on any signedness key since its low half is shared.
  always_comb begin
    hit_s = (REUSE_EN != 0) && cache_valid_q &&
            (req_rs1 == key_a_q) && (req_rs2 == key_b_q) &&
            ((req_op == MUL_OP_MUL) || (sign_flags(req_op) == key_s_q));
  end

  // Next-state, timeout counter, cache and registered-output logic.
  always_comb begin
    state_d        = state_q;
    to_d           = to_q;
    op_d           = op_q;
    rs1_d          = rs1_q;
    rs2_d          = rs2_q;
    neg_d          = neg_q;
    product_d      = product_q;
    cache_valid_d  = cache_valid_q;
    key_a_d        = key_a_q;
    key_b_d        = key_b_q;
    key_s_d        = key_s_q;
    cache_p_d      = cache_p_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    err_d          = 1'b0;
    mul_in_valid_d = 1'b0;
    mplier_d       = mplier_q;
    mcand_d        = mcand_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d  = req_op;
          rs1_d = req_rs1;
          rs2_d = req_rs2;
          neg_d = neg_s;
          if (hit_s) begin
            state_d        = ST_DONE;
            result_d       = fix_half_s;
            result_valid_d = 1'b1;
          end else begin
            state_d        = ST_ISSUE;
            mul_in_valid_d = 1'b1;
            mplier_d       = abs_a_s;
            mcand_d        = abs_b_s;
            to_d           = {TO_W{1'b0}};
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        to_d    = {TO_W{1'b0}};
      end
      ST_WAIT: begin
        // A product arriving on the last allowed cycle still wins.
        if (mul_out_valid) begin
          product_d = mul_product;
          state_d   = ST_FIX;
        end else if (to_q == TO_LAST) begin
          state_d        = ST_DONE;
          err_d          = 1'b1;
          result_d       = {XLEN{1'b0}};
          result_valid_d = 1'b1;
          cache_valid_d  = 1'b0;
        end else begin
          to_d = to_q + TO_ONE;
        end
      end
      ST_FIX: begin
        cache_p_d      = fix_p_s;
        key_a_d        = rs1_q;
        key_b_d        = rs2_q;
        key_s_d        = sign_flags(op_q);
        cache_valid_d  = 1'b1;
        result_d       = fix_half_s;
        result_valid_d = 1'b1;
        state_d        = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      to_q           <= {TO_W{1'b0}};
      op_q           <= 2'b00;
      rs1_q          <= {XLEN{1'b0}};
      rs2_q          <= {XLEN{1'b0}};
      neg_q          <= 1'b0;
      product_q      <= {(2*XLEN){1'b0}};
      cache_valid_q  <= 1'b0;
      key_a_q        <= {XLEN{1'b0}};
      key_b_q        <= {XLEN{1'b0}};
      key_s_q        <= 2'b00;
      cache_p_q      <= {(2*XLEN){1'b0}};
      result_q       <= {XLEN{1'b0}};
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
      mul_in_valid_q <= 1'b0;
      mplier_q       <= {XLEN{1'b0}};
      mcand_q        <= {XLEN{1'b0}};
    end else begin
      state_q        <= state_d;
      to_q           <= to_d;
      op_q           <= op_d;
      rs1_q          <= rs1_d;
      rs2_q          <= rs2_d;
      neg_q          <= neg_d;
      product_q      <= product_d;
      cache_valid_q  <= cache_valid_d;
      key_a_q        <= key_a_d;
      key_b_q        <= key_b_d;
      key_s_q        <= key_s_d;
      cache_p_q      <= cache_p_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      err_q          <= err_d;
      mul_in_valid_q <= mul_in_valid_d;
      mplier_q       <= mplier_d;
      mcand_q        <= mcand_d;
    end
  end

  // stall must rise in the same cycle the request is presented, so it is
  // decoded from the current state rather than registered.
  always_comb begin
    stall = ((state_q == ST_IDLE) && req_valid) || (state_q == ST_ISSUE) ||
            (state_q == ST_WAIT) || (state_q == ST_FIX);
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign err          = err_q;
  assign mul_in_valid = mul_in_valid_q;
  assign mul_mplier   = mplier_q;
  assign mul_mcand    = mcand_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl with a behavioural multiplier of
// programmable latency (or no response at all).
module tb_mul_issue_ctrl;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_rs1, req_rs2;
  logic [31:0] result;
  logic        result_valid, err, stall, mul_in_valid;
  logic [31:0] mul_mplier, mul_mcand;
  logic [63:0] mul_product;
  logic        mul_out_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  // multiplier model controls
  int  lat  = 3;
  bit  stub = 1'b0;
  int  cnt  = 0;
  bit  busy = 1'b0;

  // reference cache model
  bit          c_valid = 1'b0;
  logic [31:0] c_a, c_b;
  logic [1:0]  c_s;

  always #5 clk = ~clk;

  mul_issue_ctrl #(.XLEN(32), .TIMEOUT(TIMEOUT), .REUSE_EN(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_rs1      (req_rs1),
    .req_rs2      (req_rs2),
    .result       (result),
    .result_valid (result_valid),
    .err          (err),
    .stall        (stall),
    .mul_in_valid (mul_in_valid),
    .mul_mplier   (mul_mplier),
    .mul_mcand    (mul_mcand),
    .mul_product  (mul_product),
    .mul_out_valid(mul_out_valid)
  );

  // Behavioural multiplier: product appears lat cycles after the start pulse.
  always @(posedge clk) begin
    mul_out_valid <= 1'b0;
    if (busy) begin
      if (cnt <= 1) begin
        mul_out_valid <= 1'b1;
        busy          <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
    if (mul_in_valid === 1'b1 && !stub) begin
      mul_product <= {32'h0, mul_mplier} * {32'h0, mul_mcand};
      if (lat <= 1) begin
        mul_out_valid <= 1'b1;
        busy          <= 1'b0;
      end else begin
        busy <= 1'b1;
        cnt  <= lat - 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Signedness of each operand, straight from the RV32M definitions.
  function automatic logic [1:0] ref_flags(input logic [1:0] op);
    bit a_signed, b_signed;
    a_signed = (op != 2'b11);
    b_signed = (op == 2'b00) || (op == 2'b01);
    return {a_signed, b_signed};
  endfunction

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [1:0]  f;
    logic [63:0] ea, eb, p;
    f  = ref_flags(op);
    ea = f[1] ? {{32{a[31]}}, a} : {32'h0, a};
    eb = f[0] ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] ref_mag(input bit is_signed, input logic [31:0] x);
    return (is_signed && x[31]) ? (32'd0 - x) : x;
  endfunction

  function automatic bit model_hit(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return c_valid && (a == c_a) && (b == c_b) && ((op == 2'b00) || (ref_flags(op) == c_s));
  endfunction

  // Presents one request and observes it until result_valid (bounded).
  task automatic run_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic err_o, output int k_done,
                         output int k_in, output int k_out, output logic [31:0] mp,
                         output logic [31:0] mc, output bit stall_ok);
    res = 32'h0; err_o = 1'b0; k_done = -1; k_in = -1; k_out = -1;
    mp = 32'h0; mc = 32'h0;
    @(negedge clk);
    req_op = op; req_rs1 = a; req_rs2 = b; req_valid = 1'b1;
    #1;
    stall_ok = (stall === 1'b1);
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mul_in_valid === 1'b1 && k_in < 0) begin
        k_in = k; mp = mul_mplier; mc = mul_mcand;
      end
      if (mul_out_valid === 1'b1 && k_out < 0) k_out = k;
      if (result_valid === 1'b1) begin
        res = result; err_o = err; k_done = k;
        if (stall !== 1'b0) stall_ok = 1'b0;
        break;
      end
      if (stall !== 1'b1) stall_ok = 1'b0;
    end
  endtask

  // One normal transaction checked against expected result and hit/miss.
  task automatic txn(input string tag, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_res, input bit exp_hit);
    logic [31:0] res, mp, mc;
    logic        e;
    int          kd, ki, ko, exp_lat;
    bit          sok;
    logic [1:0]  f;
    run_req(op, a, b, res, e, kd, ki, ko, mp, mc, sok);
    f = ref_flags(op);
    chk($sformatf("%s result", tag), res, exp_res);
    chk($sformatf("%s err", tag), e, 1'b0);
    chk($sformatf("%s issued", tag), (ki >= 0), !exp_hit);
    chk($sformatf("%s stall", tag), sok, 1'b1);
    if (exp_hit) begin
      exp_lat = 1;
    end else begin
      chk($sformatf("%s mul_out seen", tag), (ko >= 0), 1'b1);
      chk($sformatf("%s mplier", tag), mp, ref_mag(f[1], a));
      chk($sformatf("%s mcand", tag), mc, ref_mag(f[0], b));
      exp_lat = ko - ki + 3;
    end
    chk($sformatf("%s latency", tag), kd, exp_lat);
    if (!exp_hit) begin
      c_valid = 1'b1; c_a = a; c_b = b; c_s = f;
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          hit;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [31:0] res, mp, mc, ra, rb;
    logic        e;
    int          kd, ki, ko;
    bit          sok, bad, late_seen;
    logic [1:0]  rop;

    vecs[0]  = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 1'b1};
    vecs[3]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
    vecs[4]  = '{2'b11, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
    vecs[5]  = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    vecs[6]  = '{2'b10, 32'h00000005, 32'h80000000, 32'h00000002, 1'b0};
    vecs[7]  = '{2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
    vecs[8]  = '{2'b01, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b1};
    vecs[9]  = '{2'b10, 32'h00000007, 32'hFFFFFFFD, 32'h00000006, 1'b0};
    vecs[10] = '{2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b1};

    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_rs1 = 32'h0; req_rs2 = 32'h0;
    mul_product = 64'h0; mul_out_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset ctl", {result, result_valid, err, stall, mul_in_valid}, 36'h0);
    chk("reset mags", {mul_mplier, mul_mcand}, 64'h0);
    rst = 1'b0;

    // directed table
    foreach (vecs[i]) begin
      lat = $urandom_range(1, 5);
      txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hit);
    end

    // randomized against the reference model
    ra = 32'h1; rb = 32'h1;
    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      lat = $urandom_range(1, 6);
      if ($urandom_range(0, 9) >= 4) begin
        case ($urandom_range(0, 4))
          0: ra = 32'h0;
          1: ra = 32'h80000000;
          2: ra = 32'hFFFFFFFF;
          default: ra = $urandom;
        endcase
        case ($urandom_range(0, 4))
          0: rb = 32'h1;
          1: rb = 32'h80000000;
          2: rb = 32'hFFFFFFFF;
          default: rb = $urandom;
        endcase
      end
      txn($sformatf("rnd%0d", n), rop, ra, rb, ref_mul(rop, ra, rb), model_hit(rop, ra, rb));
    end

    // timeout: multiplier never answers
    lat = 2;
    txn("to_pre", 2'b01, 32'h3, 32'hFFFFFFFB, ref_mul(2'b01, 32'h3, 32'hFFFFFFFB),
        model_hit(2'b01, 32'h3, 32'hFFFFFFFB));
    stub = 1'b1;
    run_req(2'b11, 32'h9, 32'hB, res, e, kd, ki, ko, mp, mc, sok);
    stub = 1'b0;
    chk("timeout issued", ki, 1);
    chk("timeout latency", kd, TIMEOUT + 2);
    chk("timeout err", e, 1'b1);
    chk("timeout result", res, 32'h0);
    c_valid = 1'b0;
    txn("to_post_x", 2'b01, 32'h3, 32'hFFFFFFFB, ref_mul(2'b01, 32'h3, 32'hFFFFFFFB), 1'b0);
    txn("to_post_y", 2'b11, 32'h9, 32'hB, ref_mul(2'b11, 32'h9, 32'hB), 1'b0);

    // reset while the multiplier is busy
    lat = 3;
    txn("rst_pre", 2'b00, 32'h1234, 32'h5678, ref_mul(2'b00, 32'h1234, 32'h5678),
        model_hit(2'b00, 32'h1234, 32'h5678));
    lat = 20;
    @(negedge clk);
    req_op = 2'b11; req_rs1 = 32'hAAAA0000; req_rs2 = 32'h10; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("wait rst ctl", {result, result_valid, err, stall, mul_in_valid}, 36'h0);
    chk("wait rst mags", {mul_mplier, mul_mcand}, 64'h0);
    bad = 1'b0; late_seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (mul_out_valid === 1'b1) late_seen = 1'b1;
      if (result_valid !== 1'b0 || mul_in_valid !== 1'b0 || stall !== 1'b0) bad = 1'b1;
    end
    chk("late product seen", late_seen, 1'b1);
    chk("late product ignored", bad, 1'b0);
    c_valid = 1'b0;
    lat = 3;
    txn("rst_post", 2'b00, 32'h1234, 32'h5678, ref_mul(2'b00, 32'h1234, 32'h5678), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
